fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch sequencer directly upstream of the decoder.
- Reads 32-bit instruction words from memory through a req/ack port and presents each word to the decoder with a one-cycle decode strobe.
- Samples the decoder's valid/halt response, then either advances the PC, halts, or faults.
- Tracks the retired-instruction count and fault cause for the debug/status logic.

Parameters:
ADDR_W, 32, width of PC and memory address.
RESET_PC, 0, PC loaded at reset; must be 4-byte aligned.
TIMEOUT, 255, max cycles in FETCH without ack/err before a timeout fault; must be >= 1.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_run  in  1  level; 1 = execute, 0 = stop at next instruction boundary.
- o_mem_req  out  1  memory read request, registered.
- o_mem_addr  out  ADDR_W  read address (= PC), stable while o_mem_req = 1.
- i_mem_ack  in  1  read data valid this cycle.
- i_mem_data  in  32  instruction word, sampled on ack.
- i_mem_err  in  1  bus error this cycle.
- o_insn  out  32  instruction word to decoder.
- o_decode  out  1  decode strobe, one cycle per instruction.
- i_dec_valid  in  1  decoder valid, registered in decoder (1-cycle latency).
- i_dec_halt  in  1  decoder halt, registered in decoder (1-cycle latency).
- o_pc  out  ADDR_W  current PC.
- o_halted  out  1  halt executed; sticky until reset.
- o_fault  out  1  fault occurred; sticky until reset.
- o_fault_cause  out  2  00 none, 01 bus error, 10 timeout, 11 illegal instruction.
- o_retired  out  32  count of completed instructions, wraps mod 2^32.

Behaviour:
- Reset (i_rst_n = 0 at an edge) sets:
  - state IDLE, pc = RESET_PC, o_mem_req = 0, o_mem_addr = RESET_PC;
  - o_insn = 0, o_decode = 0, o_halted = 0, o_fault = 0, o_fault_cause = 00;
  - o_retired = 0, timeout counter = 0.
  - Reset overrides every state, including mid-FETCH. An ack arriving after reset with o_mem_req = 0 is ignored.
- States: IDLE, FETCH, ISSUE, CHECK, HALTED, FAULT. All outputs are registered.
- IDLE:
  - i_run = 1 -> FETCH; o_mem_req = 1 and o_mem_addr = pc from the next cycle.
  - Otherwise stay in IDLE.
- FETCH:
  - o_mem_req and o_mem_addr are held until the cycle after ack/err. The timeout counter increments each cycle in FETCH.
  - Priority within one cycle: i_mem_err > i_mem_ack > timeout.
  - i_mem_err = 1 -> FAULT, cause 01.
  - i_mem_ack = 1 -> o_insn <= i_mem_data, o_mem_req <= 0, -> ISSUE.
  - Counter reaches TIMEOUT with no ack/err -> FAULT, cause 10.
  - The counter clears on leaving FETCH.
  - ack/err with o_mem_req = 0 are ignored in every state.
- ISSUE:
  - o_decode = 1 for exactly this cycle; o_insn stable.
  - Always -> CHECK.
- CHECK (decoder response is valid this cycle):
  - i_dec_halt = 1 (takes precedence over valid) -> o_retired + 1, o_halted = 1, pc unchanged, -> HALTED.
  - Else i_dec_valid = 1 -> o_retired + 1, pc += 4 (wraps mod 2^ADDR_W), then:
    - i_run = 1 -> FETCH with o_mem_req = 1 next cycle;
    - i_run = 0 -> IDLE.
  - Else -> FAULT, cause 11; pc and o_retired unchanged.
- HALTED and FAULT are terminal until reset:
  - i_run is ignored; o_mem_req = 0, o_decode = 0.
  - o_pc holds the address of the halting or faulting instruction.
- i_run is only sampled in IDLE and CHECK; deasserting it mid-instruction finishes that instruction first.
- o_mem_addr[1:0] is always 00.
- Minimum instruction period with a zero-wait ack: 3 cycles (FETCH, ISSUE, CHECK).

Test Plan:
- Reset + i_run = 1; memory acks one cycle after req with 0x0000_0000 at 0x0; decoder returns halt -> one req at addr 0x0, o_decode pulses once with o_insn = 0, o_halted = 1, o_pc = 0x0, o_retired = 1, no further req.
- Three valid words at 0x0/0x4/0x8, then halt at 0xC -> requests to 0x0, 0x4, 0x8, 0xC in order; o_retired = 4; o_pc = 0xC; o_fault = 0.
- Decoder returns valid = 0, halt = 0 for the word at 0x4 -> o_fault = 1, cause 11, o_pc = 0x4, o_retired = 1.
- TIMEOUT = 4, memory never acks -> FAULT with cause 10 on the 4th FETCH cycle; o_mem_req low afterwards.
- ack and err in the same cycle -> cause 01, and o_insn is not updated.
- Two further cases:
  - i_run dropped during ISSUE of 0x0 -> instruction completes, pc = 0x4, state IDLE, no new req.
  - Reset asserted mid-FETCH with a late ack -> the ack is ignored; outputs at reset values.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer feeding the decoder with req/ack memory port
module fetch_unit #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_run,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_data,
  input  logic              i_mem_err,
  output logic [31:0]       o_insn,
  output logic              o_decode,
  input  logic              i_dec_valid,
  input  logic              i_dec_halt,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_halted,
  output logic              o_fault,
  output logic [1:0]        o_fault_cause,
  output logic [31:0]       o_retired
);
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, CHECK, HALTED, FAULT} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] PC0 = RESET_PC & ~ADDR_W'(3);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [31:0] insn_n, retired_n;
  logic [1:0] cause_n;
  logic timeout;
  assign timeout = cnt == CW'(TIMEOUT - 1);
  assign o_mem_addr = pc;
  assign o_pc = pc;
  always_comb begin
    state_n = state;
    pc_n = pc;
    insn_n = o_insn;
    retired_n = o_retired;
    cause_n = o_fault_cause;
    case (state)
      IDLE: state_n = i_run ? FETCH : IDLE;
      FETCH: begin
        if (i_mem_err) begin
          state_n = FAULT;
          cause_n = 2'b01;
        end else if (i_mem_ack) begin
          insn_n = i_mem_data;
          state_n = ISSUE;
        end else if (timeout) begin
          state_n = FAULT;
          cause_n = 2'b10;
        end
      end
      ISSUE: state_n = CHECK;
      CHECK: begin
        if (i_dec_halt) begin
          retired_n = o_retired + 32'd1;
          state_n = HALTED;
        end else if (i_dec_valid) begin
          retired_n = o_retired + 32'd1;
          pc_n = pc + ADDR_W'(4);
          state_n = i_run ? FETCH : IDLE;
        end else begin
          state_n = FAULT;
          cause_n = 2'b11;
        end
      end
      default: state_n = state;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      pc <= PC0;
      cnt <= '0;
      o_mem_req <= 1'b0;
      o_insn <= '0;
      o_decode <= 1'b0;
      o_halted <= 1'b0;
      o_fault <= 1'b0;
      o_fault_cause <= 2'b00;
      o_retired <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      cnt <= (state == FETCH && state_n == FETCH) ? cnt + 1'b1 : '0;
      o_mem_req <= state_n == FETCH;
      o_insn <= insn_n;
      o_decode <= state_n == ISSUE;
      o_halted <= o_halted | (state_n == HALTED);
      o_fault <= o_fault | (state_n == FAULT);
      o_fault_cause <= cause_n;
      o_retired <= retired_n;
    end
  end
endmodule
